reg_bank_p4_loader: RTL
=======================

REG_BANK_P4_LOADER -- requirements
Module: reg_bank_p4_loader

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning idle cycles between the last issued instruction and readback compare (range 1..15).
REQ-002 SHALL have parameter CHECK_EN, default 1, meaning readback compare is enabled; 0 skips the compare.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, named clock and reset.
REQ-004 clock  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 load_data  input  32  byte k (bits 8k+7..8k) is the value for bank register k.
REQ-007 load_mask  input  4  bit k set means register k is loaded.
REQ-008 load_valid  input  1  request present.
REQ-009 load_ready  output  1  loader accepts a request.
REQ-010 inst  output  12  {opcode[3:0], immediate[7:0]} to RegBankP4.
REQ-011 inst_en  output  1  inst is valid this cycle.
REQ-012 bank_out_0 .. bank_out_3  input  8 each  readback of RegBankP4 out_0..out_3.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err_mask  output  4  bit k set means register k read back wrong; valid only while done=1.

Function
REQ-015 SHALL accept a request on a rising edge where load_valid=1 and load_ready=1, capturing load_data and load_mask.
REQ-016 load_ready SHALL be 1 only in IDLE.
REQ-017 SHALL implement states IDLE, ISSUE, SETTLE, CHECK, DONE.
REQ-018 IDLE->ISSUE on accept with mask!=0; IDLE->DONE on accept with mask=0 (no instructions, err_mask=0).
REQ-019 ISSUE SHALL emit one LDk per cycle with inst_en=1, immediate = byte k, in ascending k over set mask bits only, with no gap cycles for clear bits.
REQ-020 First instruction SHALL appear in the cycle immediately after the accept edge; N set bits occupy exactly N consecutive cycles.
REQ-021 ISSUE->SETTLE after the last set bit if CHECK_EN=1; ISSUE->DONE if CHECK_EN=0.
REQ-022 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to CHECK.
REQ-023 CHECK (one cycle) SHALL set err_mask[k]=1 iff mask bit k set and bank_out_k != byte k; unmasked bits SHALL be 0.
REQ-024 DONE SHALL last one cycle with done=1, then return to IDLE; done=1 and load_ready=1 never coincide.
REQ-025 Whenever inst_en=0, inst SHALL be {NOP, 8'h00}.
REQ-026 Outputs inst, inst_en, done, err_mask SHALL be registered.
REQ-027 load_valid during non-IDLE states SHALL be ignored without capture.

Reset
REQ-028 Reset SHALL force IDLE immediately: load_ready=1 after reset deasserts, inst_en=0, inst={NOP,8'h00}, done=0, err_mask=0, captured data/mask=0.
REQ-029 Reset mid-operation SHALL abort: no further instructions, no done pulse for the aborted request.

Structure
REQ-030 Opcodes NOP=4'h0, LD0=4'h1, LD1=4'h2, LD2=4'h3, LD3=4'h4 and state encodings SHALL live in the shared RegBankP4 package/include, also used by RegBankP4.
REQ-031 One sub-module SHALL be natural: reg_bank_p4_mask_scan (combinational next-set-bit finder over 4-bit mask, with last flag).
REQ-032 Total RTL SHALL be 120-400 lines.

Verification
REQ-033 Bench SHALL connect loader to a real RegBankP4 and cover the scenarios below.
REQ-034 data=32'h4323FEBA, mask=4'hF -> LD0 BA, LD1 FE, LD2 23, LD3 43 on 4 consecutive cycles; done at accept+6 (SETTLE_CYCLES=1); err_mask=0.
REQ-035 data=32'h11223344, mask=4'b1010 -> only LD1 33 then LD3 11 back-to-back; out_0/out_2 unchanged; err_mask=0.
REQ-036 mask=4'h0 -> no inst_en; done one cycle after accept; err_mask=0.
REQ-037 bank_out_2 forced to 8'h00 while loading 8'h23 into reg 2 -> done with err_mask=4'b0100.
REQ-038 reset asserted during second ISSUE cycle of a mask=4'hF load -> inst_en drops same cycle, no done, load_ready=1 after deassert; next load 8'h1A to reg 0 completes normally.
REQ-039 load_valid held high through a whole transaction -> exactly one accept per IDLE visit; second request accepted only after done.

Source files
------------

// File: rtl/reg_bank_p4_pkg.sv
// Shared RegBankP4 definitions: opcodes, loader states, instruction layout
// and small field helpers used by the bank and its loader.
package reg_bank_p4_pkg;

  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned REG_W    = 8;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LD0 = 4'h1,
    OP_LD1 = 4'h2,
    OP_LD2 = 4'h3,
    OP_LD3 = 4'h4
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  typedef struct packed {
    opcode_e          op;
    logic [REG_W-1:0] imm;
  } inst_t;

  localparam inst_t INST_NOP = '{op: OP_NOP, imm: 8'h00};

  function automatic opcode_e ld_opcode(input logic [1:0] idx);
    opcode_e op;
    case (idx)
      2'd0:    op = OP_LD0;
      2'd1:    op = OP_LD1;
      2'd2:    op = OP_LD2;
      default: op = OP_LD3;
    endcase
    return op;
  endfunction

  function automatic logic [REG_W-1:0] byte_of(input logic [NUM_REGS*REG_W-1:0] d,
                                               input logic [1:0] idx);
    logic [REG_W-1:0] b;
    case (idx)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/reg_bank_p4.sv
// Four 8-bit registers loaded by LDk instructions; NOP and unknown opcodes
// leave the bank untouched.
module reg_bank_p4
  import reg_bank_p4_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] inst,
  input  logic        inst_en,
  output logic [7:0]  out_0,
  output logic [7:0]  out_1,
  output logic [7:0]  out_2,
  output logic [7:0]  out_3
);

  inst_t      ins;
  logic [7:0] r0_q, r1_q, r2_q, r3_q;

  assign ins = inst_t'(inst);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r0_q <= '0;
      r1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
    end else if (inst_en) begin
      case (ins.op)
        OP_LD0:  r0_q <= ins.imm;
        OP_LD1:  r1_q <= ins.imm;
        OP_LD2:  r2_q <= ins.imm;
        OP_LD3:  r3_q <= ins.imm;
        default: ;
      endcase
    end
  end

  assign out_0 = r0_q;
  assign out_1 = r1_q;
  assign out_2 = r2_q;
  assign out_3 = r3_q;

endmodule

// File: rtl/reg_bank_p4_loader_mask_scan.sv
// Lowest-set-bit finder over a 4-bit mask; also returns the mask with that
// bit cleared and whether it was the only bit set.
module reg_bank_p4_mask_scan
  import reg_bank_p4_pkg::*;
(
  input  logic [NUM_REGS-1:0] mask_i,
  output logic                found_o,
  output logic [1:0]          idx_o,
  output logic                last_o,
  output logic [NUM_REGS-1:0] rest_o
);

  always_comb begin
    found_o = 1'b1;
    idx_o   = 2'd0;
    casez (mask_i)
      4'b???1: idx_o = 2'd0;
      4'b??10: idx_o = 2'd1;
      4'b?100: idx_o = 2'd2;
      4'b1000: idx_o = 2'd3;
      default: found_o = 1'b0;
    endcase
  end

  assign rest_o = mask_i & ~idx_onehot(idx_o);
  assign last_o = found_o && (rest_o == '0);

endmodule

// File: rtl/reg_bank_p4_loader.sv
// Loads selected RegBankP4 registers from a 32-bit request, one LDk per
// cycle, then optionally reads the bank back and reports mismatches.
module reg_bank_p4_loader
  import reg_bank_p4_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          CHECK_EN      = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] load_data,
  input  logic [3:0]  load_mask,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [11:0] inst,
  output logic        inst_en,
  input  logic [7:0]  bank_out_0,
  input  logic [7:0]  bank_out_1,
  input  logic [7:0]  bank_out_2,
  input  logic [7:0]  bank_out_3,
  output logic        done,
  output logic [3:0]  err_mask
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e      state_q;
  logic [31:0] data_q;
  logic [3:0]  mask_q;
  logic [3:0]  pend_q;
  logic        last_q;
  logic [3:0]  cnt_q;
  inst_t       inst_q;
  logic        inst_en_q;
  logic        done_q;
  logic [3:0]  err_q;

  logic [3:0]  scan_mask, scan_rest;
  logic        scan_found, scan_last;
  logic [1:0]  scan_idx;
  logic [3:0]  chk_err;

  // One scanner serves both the first pick (from the request) and every
  // following pick (from the remaining mask), so ISSUE never idles on clear bits.
  assign scan_mask = (state_q == ST_IDLE) ? load_mask : pend_q;

  reg_bank_p4_mask_scan u_scan (
    .mask_i  (scan_mask),
    .found_o (scan_found),
    .idx_o   (scan_idx),
    .last_o  (scan_last),
    .rest_o  (scan_rest)
  );

  assign chk_err = mask_q & {bank_out_3 != data_q[31:24],
                             bank_out_2 != data_q[23:16],
                             bank_out_1 != data_q[15:8],
                             bank_out_0 != data_q[7:0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      mask_q    <= '0;
      pend_q    <= '0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      inst_q    <= INST_NOP;
      inst_en_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      inst_q    <= INST_NOP;
      inst_en_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= '0;
      case (state_q)
        ST_IDLE: begin
          if (load_valid) begin
            data_q <= load_data;
            mask_q <= load_mask;
            if (scan_found) begin
              inst_q    <= '{op: ld_opcode(scan_idx), imm: byte_of(load_data, scan_idx)};
              inst_en_q <= 1'b1;
              pend_q    <= scan_rest;
              last_q    <= scan_last;
              state_q   <= ST_ISSUE;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_ISSUE: begin
          if (last_q) begin
            if (CHECK_EN) begin
              cnt_q   <= SETTLE_LOAD;
              state_q <= ST_SETTLE;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end else begin
            inst_q    <= '{op: ld_opcode(scan_idx), imm: byte_of(data_q, scan_idx)};
            inst_en_q <= 1'b1;
            pend_q    <= scan_rest;
            last_q    <= scan_last;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) state_q <= ST_CHECK;
          else             cnt_q   <= cnt_q - 4'd1;
        end
        ST_CHECK: begin
          err_q   <= chk_err;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign load_ready = (state_q == ST_IDLE);
  assign inst       = inst_q;
  assign inst_en    = inst_en_q;
  assign done       = done_q;
  assign err_mask   = err_q;

endmodule
